// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Request/ready data-memory port between the MEM-stage access
//                controller (master) and the data memory (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_unit_if;

    logic        mem_req;    // request, held until mem_ready
    logic        mem_we;     // 1 = store, 0 = load
    logic [31:0] mem_addr;   // word-aligned address
    logic [31:0] mem_wdata;  // lane-replicated store data
    logic [3:0]  mem_wstrb;  // byte strobes, 0000 on loads
    logic        mem_ready;  // memory completes the current request
    logic [31:0] mem_rdata;  // read word, valid with mem_ready

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : RV32IM MEM-stage data-memory access controller. Latches the
//                EX/MEM access, issues a request/ready memory transaction,
//                formats store bytes/strobes, extends load data and stalls
//                the front of the pipeline until the access completes.
//  Macros      : MISALIGN_TRAP_EN - when defined, misaligned half/word
//                accesses issue no request and raise a one-cycle
//                'misaligned' pulse instead.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit (
    input  wire                clk,
    input  wire                rst,
    input  wire  [31:0]        alu_result_in,
    input  wire  [31:0]        read_data2_in,
    input  wire  [3:0]         mem_read_in,
    input  wire  [2:0]         mem_write_in,
    mem_access_unit_if.master  mem_bus,
    output logic [31:0]        load_data,
    output logic               stall,
    output logic               misaligned
);

    // FSM encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // funct3 load encodings
    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    // store size encodings
    localparam logic [1:0] c_SZ_B = 2'b00;
    localparam logic [1:0] c_SZ_H = 2'b01;

    logic [1:0]  r_state;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_load_data;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_load_f3;
    logic        r_is_load;

    logic        w_access;
    logic        w_is_load;
    logic        w_misalign;
    logic        w_issue;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_lane;
    logic [31:0] w_load_fmt;

    // A load takes priority when both enables are set.
    assign w_access  = mem_read_in[3] | mem_write_in[2];
    assign w_is_load = mem_read_in[3];

`ifdef MISALIGN_TRAP_EN
    logic r_misaligned;

    // Flag half accesses on odd addresses and word accesses off a word boundary.
    always_comb begin
        w_misalign = 1'b0;
        if (w_is_load) begin
            case (mem_read_in[1:0])
                2'b00:   w_misalign = 1'b0;                    // LB / LBU
                2'b01:   w_misalign = alu_result_in[0];        // LH / LHU
                default: w_misalign = |alu_result_in[1:0];     // LW and reserved
            endcase
        end else if (mem_write_in[2]) begin
            case (mem_write_in[1:0])
                c_SZ_B:  w_misalign = 1'b0;
                c_SZ_H:  w_misalign = alu_result_in[0];
                default: w_misalign = |alu_result_in[1:0];
            endcase
        end
    end

    // One-cycle pulse in the cycle after a misaligned access is seen in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= (r_state == c_IDLE) & w_access & w_misalign;
        end
    end

    assign misaligned = r_misaligned;
`else
    // Without trapping every access is issued; lanes simply truncate at the word edge.
    assign w_misalign = 1'b0;
    assign misaligned = 1'b0;
`endif

    assign w_issue = w_access & ~w_misalign;

    // Replicate store data across lanes and build strobes from the low address bits.
    always_comb begin
        w_wdata = read_data2_in;
        w_wstrb = 4'b1111;
        case (mem_write_in[1:0])
            c_SZ_B: begin
                w_wdata = {4{read_data2_in[7:0]}};
                w_wstrb = 4'b0001 << alu_result_in[1:0];
            end
            c_SZ_H: begin
                w_wdata = {2{read_data2_in[15:0]}};
                w_wstrb = 4'b0011 << {alu_result_in[1], 1'b0};
            end
            default: begin
                w_wdata = read_data2_in;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    // Select the addressed lane of the returned word and extend it per funct3.
    assign w_lane = mem_bus.mem_rdata >> {r_addr_lo, 3'b000};

    always_comb begin
        w_load_fmt = w_lane;
        case (r_load_f3)
            c_F3_LB:  w_load_fmt = {{24{w_lane[7]}},  w_lane[7:0]};
            c_F3_LH:  w_load_fmt = {{16{w_lane[15]}}, w_lane[15:0]};
            c_F3_LBU: w_load_fmt = {24'd0, w_lane[7:0]};
            c_F3_LHU: w_load_fmt = {16'd0, w_lane[15:0]};
            default:  w_load_fmt = w_lane;     // LW and reserved encodings
        endcase
    end

    // Access FSM: latch in IDLE, hold the request in WAIT, one settle cycle in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'b0000;
            r_load_data <= 32'd0;
            r_addr_lo   <= 2'b00;
            r_load_f3   <= 3'b000;
            r_is_load   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_issue) begin
                        r_state     <= c_WAIT;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= ~w_is_load;
                        r_mem_addr  <= {alu_result_in[31:2], 2'b00};
                        r_mem_wdata <= w_is_load ? 32'd0 : w_wdata;
                        r_mem_wstrb <= w_is_load ? 4'b0000 : w_wstrb;
                        r_addr_lo   <= alu_result_in[1:0];
                        r_load_f3   <= mem_read_in[2:0];
                        r_is_load   <= w_is_load;
                    end
                end
                c_WAIT: begin
                    if (mem_bus.mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= c_DONE;
                        if (r_is_load) begin
                            r_load_data <= w_load_fmt;
                        end
                    end
                end
                c_DONE: begin
                    // Same instruction still sits in EX/MEM; ignore it.
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Hold the front of the pipeline while an access is starting or in flight.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            stall = ((r_state == c_IDLE) & w_issue) | (r_state == c_WAIT);
        end
    end

    assign mem_bus.mem_req   = r_mem_req;
    assign mem_bus.mem_we    = r_mem_we;
    assign mem_bus.mem_addr  = r_mem_addr;
    assign mem_bus.mem_wdata = r_mem_wdata;
    assign mem_bus.mem_wstrb = r_mem_wstrb;
    assign load_data         = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit with a behavioural
//                reference model and randomized back-to-back accesses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result_in;
    logic [31:0] read_data2_in;
    logic [3:0]  mem_read_in;
    logic [2:0]  mem_write_in;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ld = 32'd0;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk           (clk),
        .rst           (rst),
        .alu_result_in (alu_result_in),
        .read_data2_in (read_data2_in),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .mem_bus       (bus.master),
        .load_data     (load_data),
        .stall         (stall),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    // Drive just after the rising edge; sample on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rd);
        logic [31:0] lane;
        logic [31:0] b;
        logic [31:0] h;
        lane = rd >> (8 * int'(a));
        b    = lane & 32'hFF;
        h    = lane & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return lane;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] one;
        one = 4'd1;
        if (sz == 2'd0) return one << a;
        if (sz == 2'd1) return (a >= 2'd2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    // ---------------- transaction driver ----------------
    // Presents an access, returns mem_ready after 'lat' request cycles, checks every cycle.
    task automatic run_access(input logic [3:0] rd, input logic [2:0] wr,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] rdata, input int lat, input string tag);
        logic is_load;
        logic is_store;
        is_load  = rd[3];
        is_store = wr[2] & ~rd[3];
        cyc();
        alu_result_in = addr;
        read_data2_in = data;
        mem_read_in   = rd;
        mem_write_in  = wr;
        bus.mem_ready = 1'($urandom % 2);   // stray ready in IDLE must be ignored
        bus.mem_rdata = $urandom;
        smp();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL %s stall_c0: got %b expected 1", tag, stall);
        end
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s req_c0: got %b expected 0", tag, bus.mem_req);
        end
        for (int c = 1; c <= lat; c++) begin
            cyc();
            bus.mem_ready = (c == lat);
            bus.mem_rdata = (c == lat) ? rdata : $urandom;
            smp();
            checks++;
            if (bus.mem_req !== 1'b1 || stall !== 1'b1) begin
                errors++;
                $display("FAIL %s wait_c%0d: req %b stall %b expected 1 1", tag, c, bus.mem_req, stall);
            end
            checks++;
            if (bus.mem_addr !== (addr & 32'hFFFFFFFC) || bus.mem_we !== is_store) begin
                errors++;
                $display("FAIL %s addr_we: got %h/%b expected %h/%b", tag, bus.mem_addr, bus.mem_we,
                         addr & 32'hFFFFFFFC, is_store);
            end
            checks++;
            if (bus.mem_wstrb !== (is_load ? 4'h0 : m_wstrb(wr[1:0], addr[1:0]))) begin
                errors++;
                $display("FAIL %s wstrb: got %b expected %b", tag, bus.mem_wstrb,
                         is_load ? 4'h0 : m_wstrb(wr[1:0], addr[1:0]));
            end
            if (is_store) begin
                checks++;
                if (bus.mem_wdata !== m_wdata(wr[1:0], data)) begin
                    errors++;
                    $display("FAIL %s wdata: got %h expected %h", tag, bus.mem_wdata, m_wdata(wr[1:0], data));
                end
            end
            checks++;
            if (load_data !== exp_ld) begin
                errors++;
                $display("FAIL %s ld_hold: got %h expected %h", tag, load_data, exp_ld);
            end
        end
        if (is_load) exp_ld = m_load(rd[2:0], addr[1:0], rdata);
        cyc();
        bus.mem_ready = 1'($urandom % 2);   // ignored in DONE
        bus.mem_rdata = $urandom;
        smp();
        checks++;
        if (stall !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s done: stall %b req %b expected 0 0", tag, stall, bus.mem_req);
        end
        checks++;
        if (load_data !== exp_ld) begin
            errors++;
            $display("FAIL %s load_data: got %h expected %h", tag, load_data, exp_ld);
        end
    endtask

    task automatic idle_cycle();
        cyc();
        mem_read_in   = 4'd0;
        mem_write_in  = 3'd0;
        bus.mem_ready = 1'($urandom % 2);
        bus.mem_rdata = $urandom;
        smp();
        checks++;
        if (stall !== 1'b0 || bus.mem_req !== 1'b0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL idle: stall %b req %b mis %b expected 0 0 0", stall, bus.mem_req, misaligned);
        end
        checks++;
        if (load_data !== exp_ld) begin
            errors++;
            $display("FAIL idle_ld: got %h expected %h", load_data, exp_ld);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst           = 1'b1;
        alu_result_in = 32'h100;
        read_data2_in = 32'd0;
        mem_read_in   = 4'b1010;
        mem_write_in  = 3'd0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        cyc();
        cyc();
        smp();
        checks++;
        if (bus.mem_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'd0) begin
            errors++;
            $display("FAIL reset: req %b stall %b ld %h expected 0 0 0", bus.mem_req, stall, load_data);
        end
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 ||
            bus.mem_wstrb !== 4'd0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: we %b addr %h wdata %h wstrb %b mis %b expected all 0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, misaligned);
        end
        cyc();
        rst         = 1'b0;
        mem_read_in = 4'd0;
        exp_ld      = 32'd0;
        smp();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_stall: got %b expected 0", stall);
        end
    endtask

    task automatic test_lw();
        run_access(4'b1010, 3'd0, 32'h100, 32'd0, 32'hDEADBEEF, 1, "lw");
        checks++;
        if (load_data !== 32'hDEADBEEF || bus.mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL lw_const: ld %h addr %h expected deadbeef 00000100", load_data, bus.mem_addr);
        end
        idle_cycle();
    endtask

    task automatic test_load_formats();
        run_access(4'b1000, 3'd0, 32'h103, 32'd0, 32'h80FF1234, 2, "lb");
        checks++;
        if (load_data !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb_const: got %h expected ffffff80", load_data);
        end
        run_access(4'b1100, 3'd0, 32'h103, 32'd0, 32'h80FF1234, 1, "lbu");
        checks++;
        if (load_data !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu_const: got %h expected 00000080", load_data);
        end
        run_access(4'b1101, 3'd0, 32'h102, 32'd0, 32'h80FF1234, 1, "lhu");
        checks++;
        if (load_data !== 32'h000080FF) begin
            errors++;
            $display("FAIL lhu_const: got %h expected 000080ff", load_data);
        end
        idle_cycle();
    endtask

    task automatic test_sb_delay();
        run_access(4'd0, 3'b100, 32'h201, 32'h000000AB, 32'd0, 4, "sb");
        checks++;
        if (bus.mem_wdata !== 32'hABABABAB || bus.mem_wstrb !== 4'b0010 || load_data !== exp_ld) begin
            errors++;
            $display("FAIL sb_const: wdata %h wstrb %b expected abababab 0010", bus.mem_wdata, bus.mem_wstrb);
        end
        idle_cycle();
    endtask

    task automatic test_load_store_reset();
        cyc();
        alu_result_in = 32'h40;
        read_data2_in = 32'h12345678;
        mem_read_in   = 4'b1010;
        mem_write_in  = 3'b110;
        bus.mem_ready = 1'b0;
        smp();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL ldst_stall: got %b expected 1", stall);
        end
        cyc();
        smp();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_wstrb !== 4'd0) begin
            errors++;
            $display("FAIL ldst_priority: req %b we %b wstrb %b expected 1 0 0000",
                     bus.mem_req, bus.mem_we, bus.mem_wstrb);
        end
        cyc();
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        smp();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall: got %b expected 0", stall);
        end
        cyc();
        rst           = 1'b0;
        mem_read_in   = 4'd0;
        mem_write_in  = 3'd0;
        exp_ld        = 32'd0;
        smp();
        checks++;
        if (bus.mem_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: req %b stall %b ld %h expected 0 0 0", bus.mem_req, stall, load_data);
        end
        idle_cycle();
    endtask

    task automatic test_misalign();
        logic [31:0] d;
        d = $urandom;
`ifdef MISALIGN_TRAP_EN
        cyc();
        alu_result_in = 32'h302;
        read_data2_in = d;
        mem_read_in   = 4'd0;
        mem_write_in  = 3'b110;
        smp();
        checks++;
        if (stall !== 1'b0 || bus.mem_req !== 1'b0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL mis_c0: stall %b req %b mis %b expected 0 0 0", stall, bus.mem_req, misaligned);
        end
        cyc();
        mem_write_in = 3'd0;
        smp();
        checks++;
        if (misaligned !== 1'b1 || bus.mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse: mis %b req %b stall %b expected 1 0 0", misaligned, bus.mem_req, stall);
        end
        idle_cycle();
`else
        run_access(4'd0, 3'b110, 32'h302, d, 32'd0, 2, "sw_unal");
        checks++;
        if (bus.mem_addr !== 32'h300 || bus.mem_wstrb !== 4'hF || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL sw_unal_const: addr %h wstrb %b mis %b expected 00000300 1111 0",
                     bus.mem_addr, bus.mem_wstrb, misaligned);
        end
        idle_cycle();
`endif
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] a;
        logic        word;
        logic        half;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom % 3)
                0: begin
                    rd = {1'b1, f3_tab[$urandom % 8]};
                    wr = 3'd0;
                end
                1: begin
                    rd = 4'd0;
                    wr = {1'b1, 2'($urandom % 3)};
                end
                default: begin
                    rd = {1'b1, f3_tab[$urandom % 8]};
                    wr = {1'b1, 2'($urandom % 3)};
                end
            endcase
            if (rd[3]) begin
                word = !(rd[2:0] == 3'd0 || rd[2:0] == 3'd1 || rd[2:0] == 3'd4 || rd[2:0] == 3'd5);
                half = (rd[2:0] == 3'd1 || rd[2:0] == 3'd5);
            end else begin
                word = (wr[1:0] == 2'd2);
                half = (wr[1:0] == 2'd1);
            end
            if (word) a[1:0] = 2'b00;
`ifdef MISALIGN_TRAP_EN
            if (half) a[0] = 1'b0;
`endif
            run_access(rd, wr, a, $urandom, $urandom, 1 + int'($urandom % 4), "rand");
            if ($urandom % 4 == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_formats();
        test_sb_delay();
        test_load_store_reset();
        test_misalign();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
